// File: rtl/eeg_fram_rd_agu_if.sv
// Bus bundle for eeg_fram_rd_agu: config command, FRAM address/data channels
// and packed output beats. The master modport is the read front-end itself.
interface eeg_fram_rd_agu_if #(
  parameter int NUM_DW   = 4,
  parameter int ADD_AW   = 12,
  parameter int DAT_DW   = 4,
  parameter int LEN_DW   = 12,
  parameter int PACK_NUM = 4
);
  logic                              cfg_info_vld;
  logic                              cfg_info_rdy;
  logic [NUM_DW*ADD_AW-1:0]          cfg_base_add;
  logic [ADD_AW-1:0]                 cfg_stride;
  logic [LEN_DW-1:0]                 cfg_len;

  logic [NUM_DW-1:0]                 etof_add_vld;
  logic [NUM_DW-1:0]                 etof_add_lst;
  logic [NUM_DW-1:0]                 etof_add_rdy;
  logic [NUM_DW*ADD_AW-1:0]          etof_add_add;

  logic [NUM_DW-1:0]                 ftoe_dat_vld;
  logic [NUM_DW-1:0]                 ftoe_dat_lst;
  logic [NUM_DW-1:0]                 ftoe_dat_rdy;
  logic [NUM_DW*DAT_DW-1:0]          ftoe_dat_dat;

  logic [NUM_DW-1:0]                 out_dat_vld;
  logic [NUM_DW-1:0]                 out_dat_lst;
  logic [NUM_DW-1:0]                 out_dat_rdy;
  logic [NUM_DW*PACK_NUM*DAT_DW-1:0] out_dat_dat;

  modport master (
    input  cfg_info_vld, cfg_base_add, cfg_stride, cfg_len,
    input  etof_add_rdy, ftoe_dat_vld, ftoe_dat_lst, ftoe_dat_dat, out_dat_rdy,
    output cfg_info_rdy, etof_add_vld, etof_add_lst, etof_add_add,
    output ftoe_dat_rdy, out_dat_vld, out_dat_lst, out_dat_dat
  );

  modport slave (
    output cfg_info_vld, cfg_base_add, cfg_stride, cfg_len,
    output etof_add_rdy, ftoe_dat_vld, ftoe_dat_lst, ftoe_dat_dat, out_dat_rdy,
    input  cfg_info_rdy, etof_add_vld, etof_add_lst, etof_add_add,
    input  ftoe_dat_rdy, out_dat_vld, out_dat_lst, out_dat_dat
  );
endinterface

// File: rtl/eeg_fram_rd_agu.sv
// FRAM read front-end: per-lane strided address generator plus word packer.
// Optional protocol checker on ERR_FLAG is built when EEG_FRAM_RD_CHK_EN is defined.
module eeg_fram_rd_agu #(
  parameter int NUM_DW   = 4,
  parameter int ADD_AW   = 12,
  parameter int DAT_DW   = 4,
  parameter int LEN_DW   = 12,
  parameter int PACK_NUM = 4,
  parameter int OST_MAX  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  eeg_fram_rd_agu_if.master if_agu,
  output logic              o_is_idle,
  output logic              o_err_flag
);
  localparam int OST_W  = $clog2(OST_MAX + 1);
  localparam int PC_W   = $clog2(PACK_NUM + 1);
  localparam int BEAT_W = PACK_NUM * DAT_DW;
  localparam logic [OST_W-1:0] OST_FULL  = OST_W'(OST_MAX);
  localparam logic [PC_W-1:0]  PACK_LAST = PC_W'(PACK_NUM - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              r_state;
  logic [LEN_DW-1:0]   r_len;
  logic [ADD_AW-1:0]   r_stride;
  logic [ADD_AW-1:0]   r_add  [NUM_DW];
  logic [LEN_DW-1:0]   r_k    [NUM_DW];
  logic [LEN_DW-1:0]   r_wcnt [NUM_DW];
  logic [OST_W-1:0]    r_ost  [NUM_DW];
  logic [PC_W-1:0]     r_c    [NUM_DW];
  logic [BEAT_W-1:0]   r_hold [NUM_DW];
  logic [NUM_DW-1:0]   r_out_vld, r_out_lst, r_done;

  logic                      w_run, w_cfg_ena;
  logic [NUM_DW-1:0]         w_add_vld, w_add_lst, w_add_xfer;
  logic [NUM_DW-1:0]         w_dat_rdy, w_dat_xfer, w_wlast;
  logic [NUM_DW*ADD_AW-1:0]  w_add_bus;
  logic [NUM_DW*BEAT_W-1:0]  w_out_bus;

  assign w_run     = (r_state == S_RUN);
  assign w_cfg_ena = if_agu.cfg_info_vld && (r_state == S_IDLE);

  // NOTE: every signal written in always_comb is defaulted first, so no path can infer a latch.
  always_comb begin
    w_add_vld  = '0;
    w_add_lst  = '0;
    w_add_xfer = '0;
    w_dat_rdy  = '0;
    w_dat_xfer = '0;
    w_wlast    = '0;
    w_add_bus  = '0;
    w_out_bus  = '0;
    for (int i = 0; i < NUM_DW; i++) begin
      w_add_vld[i]  = w_run && (r_k[i] < r_len) && (r_ost[i] < OST_FULL);
      w_add_lst[i]  = w_add_vld[i] && (r_k[i] == r_len - LEN_DW'(1));
      w_add_xfer[i] = w_add_vld[i] && if_agu.etof_add_rdy[i];
      w_dat_rdy[i]  = w_run && !r_out_vld[i];
      w_dat_xfer[i] = w_dat_rdy[i] && if_agu.ftoe_dat_vld[i];
      w_wlast[i]    = (r_wcnt[i] == r_len - LEN_DW'(1));
      w_add_bus[i*ADD_AW +: ADD_AW] = r_add[i];
      w_out_bus[i*BEAT_W +: BEAT_W] = r_hold[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_len     <= '0;
      r_stride  <= '0;
      r_out_vld <= '0;
      r_out_lst <= '0;
      r_done    <= '0;
      // NOTE: the packing registers are plain flops that drive OUT_DAT_DAT, so they are reset too.
      for (int i = 0; i < NUM_DW; i++) begin
        r_add[i]  <= '0;
        r_k[i]    <= '0;
        r_wcnt[i] <= '0;
        r_ost[i]  <= '0;
        r_c[i]    <= '0;
        r_hold[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE:  if (w_cfg_ena) r_state <= S_RUN;
        S_RUN:   if (&r_done) r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase

      if (w_cfg_ena) begin
        r_len    <= if_agu.cfg_len;
        r_stride <= if_agu.cfg_stride;
      end

      for (int i = 0; i < NUM_DW; i++) begin
        if (w_cfg_ena) begin
          r_add[i]     <= if_agu.cfg_base_add[i*ADD_AW +: ADD_AW];
          r_k[i]       <= '0;
          r_wcnt[i]    <= '0;
          r_ost[i]     <= '0;
          r_c[i]       <= '0;
          r_hold[i]    <= '0;
          r_out_vld[i] <= 1'b0;
          r_out_lst[i] <= 1'b0;
          r_done[i]    <= (if_agu.cfg_len == '0);
        end else begin
          if (w_add_xfer[i]) begin
            r_add[i] <= r_add[i] + r_stride;
            r_k[i]   <= r_k[i] + LEN_DW'(1);
          end

          // Saturate at zero so a stray data word cannot wrap the outstanding count.
          if (w_add_xfer[i] && !w_dat_xfer[i])
            r_ost[i] <= r_ost[i] + OST_W'(1);
          else if (!w_add_xfer[i] && w_dat_xfer[i] && (r_ost[i] != '0))
            r_ost[i] <= r_ost[i] - OST_W'(1);

          if (w_dat_xfer[i]) begin
            r_hold[i][32'(r_c[i])*DAT_DW +: DAT_DW] <= if_agu.ftoe_dat_dat[i*DAT_DW +: DAT_DW];
            r_c[i]    <= r_c[i] + PC_W'(1);
            r_wcnt[i] <= r_wcnt[i] + LEN_DW'(1);
            if ((r_c[i] == PACK_LAST) || w_wlast[i]) begin
              r_out_vld[i] <= 1'b1;
              r_out_lst[i] <= w_wlast[i];
            end
          end else if (r_out_vld[i] && if_agu.out_dat_rdy[i]) begin
            r_out_vld[i] <= 1'b0;
            r_out_lst[i] <= 1'b0;
            r_c[i]       <= '0;
            r_hold[i]    <= '0;
            if (r_out_lst[i]) r_done[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign o_is_idle           = (r_state == S_IDLE);
  assign if_agu.cfg_info_rdy = (r_state == S_IDLE);
  assign if_agu.etof_add_vld = w_add_vld;
  assign if_agu.etof_add_lst = w_add_lst;
  assign if_agu.etof_add_add = w_add_bus;
  assign if_agu.ftoe_dat_rdy = w_dat_rdy;
  assign if_agu.out_dat_vld  = r_out_vld;
  assign if_agu.out_dat_lst  = r_out_lst;
  assign if_agu.out_dat_dat  = w_out_bus;

`ifdef EEG_FRAM_RD_CHK_EN
  logic              r_err;
  logic [NUM_DW-1:0] w_err;

  always_comb begin
    w_err = '0;
    for (int i = 0; i < NUM_DW; i++) begin
      w_err[i] = (w_dat_xfer[i] && ((r_ost[i] == '0) || (if_agu.ftoe_dat_lst[i] != w_wlast[i])))
              || (if_agu.ftoe_dat_vld[i] && !w_run);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      r_err <= 1'b0;
    else if (|w_err) r_err <= 1'b1;
  end

  assign o_err_flag = r_err;
`else
  logic w_unused_lst;
  assign w_unused_lst = ^if_agu.ftoe_dat_lst;
  assign o_err_flag   = 1'b0;
`endif
endmodule
